// File: rtl/usb_fifo_tx.sv
// usb_fifo_tx: buffered transmit path to a USB FIFO chip.
// Optional word counter enabled by USB_FIFO_TX_STATS_EN.
module usb_fifo_tx #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 1,
  parameter int RECOVER_CYC = 1
) (
  input  logic                       clk,
  input  logic                       reset_in,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       txe,
  output logic                       rd,
  output logic                       wr,
  output logic [DATA_W-1:0]          data_out,
  output logic                       reset_out,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOVER
  } state_t;

  state_t            state;
  logic [15:0]       cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [LW-1:0]     next_level;
  logic              txe_m;
  logic              txe_s;
  logic              push;
  logic              pop;

  assign rd   = 1'b1;
  assign push = in_valid & in_ready;
  assign pop  = (state == IDLE) &
                (level != '0) & ~txe_s;

  // Two-flop synchronizer for the chip's txe flag
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      txe_m <= 1'b1;
      txe_s <= 1'b1;
    end else begin
      txe_m <= txe;
      txe_s <= txe_m;
    end
  end

  // Chip reset releases on the first clock after reset_in rises
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) reset_out <= 1'b0;
    else           reset_out <= 1'b1;
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    next_level = level;
    case ({push, pop})
      2'b10:   next_level = level + LW'(1);
      2'b01:   next_level = level - LW'(1);
      default: next_level = level;
    endcase
  end

  // Buffer storage; contents are don't-care until pointed at
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  // Pointers, level and registered ready flag
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      level    <= next_level;
      in_ready <= (next_level != LW'(DEPTH));
    end
  end

  // Write strobe sequencer; txe_s only matters in IDLE
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state    <= IDLE;
      wr       <= 1'b1;
      data_out <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            data_out <= mem[rptr];
            state    <= SETUP;
            cnt      <= 16'(SETUP_CYC - 1);
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= STROBE;
            wr    <= 1'b0;
            cnt   <= 16'(PULSE_CYC - 1);
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            wr <= 1'b1;
            if (RECOVER_CYC == 0) begin
              state <= IDLE;
            end else begin
              state <= RECOVER;
              cnt   <= 16'(RECOVER_CYC - 1);
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RECOVER: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef USB_FIFO_TX_STATS_EN
  logic strobe_end;
  assign strobe_end = (state == STROBE) &
                      (cnt == '0);

  // Count completed write strobes, wrapping at 16 bits
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in)       word_count <= '0;
    else if (strobe_end) word_count <= word_count + 16'd1;
  end
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_usb_fifo_tx.sv
// tb_usb_fifo_tx: scoreboard bench for usb_fifo_tx.
// Second instance covers a long setup/pulse timing.
module tb_usb_fifo_tx;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        txe = 1'b0;
  logic        rd;
  logic        wr;
  logic [7:0]  data_out;
  logic        reset_out;
  logic [4:0]  level;
  logic [15:0] word_count;

  logic [7:0]  b_in_data = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic        b_txe = 1'b0;
  logic        b_rd;
  logic        b_wr;
  logic [7:0]  b_data_out;
  logic        b_reset_out;
  logic [4:0]  b_level;
  logic [15:0] b_word_count;

  always #5 clk = ~clk;

  usb_fifo_tx u_dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .txe        (txe),
    .rd         (rd),
    .wr         (wr),
    .data_out   (data_out),
    .reset_out  (reset_out),
    .level      (level),
    .word_count (word_count)
  );

  usb_fifo_tx #(
    .SETUP_CYC   (2),
    .PULSE_CYC   (3),
    .RECOVER_CYC (0)
  ) u_dut2 (
    .clk        (clk),
    .reset_in   (reset_in),
    .in_data    (b_in_data),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .txe        (b_txe),
    .rd         (b_rd),
    .wr         (b_wr),
    .data_out   (b_data_out),
    .reset_out  (b_reset_out),
    .level      (b_level),
    .word_count (b_word_count)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         pulses = 0;
  int         wc_exp = 0;
  int         lowcnt = 0;
  logic       prev_wr = 1'b1;
  logic [7:0] held = '0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Monitor: every falling wr presents a word to the scoreboard
  always @(negedge clk) begin
    if (!reset_in) begin
      prev_wr = 1'b1;
      lowcnt  = 0;
      wc_exp  = 0;
    end else begin
      if (!wr && prev_wr) begin
        pulses++;
        lowcnt = 1;
        held   = data_out;
        if (exp_q.size() == 0)
          check("unexpected_strobe", 1, 0);
        else
          check("strobe_data", data_out,
                exp_q.pop_front());
      end else if (!wr) begin
        lowcnt++;
        check("data_hold", data_out, held);
      end else if (!prev_wr) begin
        check("pulse_len", lowcnt, 1);
        wc_exp++;
      end
      prev_wr = wr;
    end
  end

  task automatic push(input logic [7:0] d,
                      input logic acc);
    check("in_ready", in_ready, acc);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    if (acc) exp_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    int i = 0;
    while (exp_q.size() != 0 && i < n) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_wr_low(input int n);
    int i = 0;
    while (wr && i < n) begin
      @(negedge clk);
      i++;
    end
    check("wr_low_timeout", wr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [0:13] wr_pat;
    logic [7:0]  d_exp;

    // Reset state
    #1 reset_in = 1'b0;
    #2;
    check("rst_wr", wr, 1);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_reset_out", reset_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_rd", rd, 1);
    check("rst_word_count", word_count, 0);
    repeat (3) @(negedge clk);
    reset_in = 1'b1;
    #1 check("rel_reset_out_pre", reset_out, 0);
    @(negedge clk);
    check("rel_reset_out", reset_out, 1);
    check("rel_in_ready", in_ready, 1);
    repeat (4) @(negedge clk);

    // Single word latency
    push(8'hA5, 1'b1);
    check("t1_level_e", level, 1);
    check("t1_data_e", data_out, 0);
    @(negedge clk);
    check("t1_level_e1", level, 0);
    check("t1_data_e1", data_out, 8'hA5);
    check("t1_wr_e1", wr, 1);
    @(negedge clk);
    check("t1_wr_e2", wr, 0);
    @(negedge clk);
    check("t1_wr_e3", wr, 1);
    wait_drain(20);

    // Fill to full with txe high, then drain
    txe = 1'b1;
    repeat (3) @(negedge clk);
    p0 = pulses;
    for (int i = 0; i < 16; i++)
      push(8'(i), 1'b1);
    check("t2_level_full", level, 16);
    push(8'h99, 1'b0);
    check("t2_level_17", level, 16);
    check("t2_no_strobe", pulses - p0, 0);
    txe = 1'b0;
    wait_drain(200);
    check("t2_pulses", pulses - p0, 16);
    check("t2_level_end", level, 0);
    check("t2_ready_end", in_ready, 1);

    // txe rises mid-strobe
    p0 = pulses;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    wait_wr_low(10);
    txe = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_pulses_hold", pulses - p0, 1);
    check("t3_level_hold", level, 2);
    check("t3_wr_idle", wr, 1);
    txe = 1'b0;
    wait_drain(100);
    check("t3_pulses", pulses - p0, 3);

    // Reset during strobe with five words queued
    txe = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++)
      push(8'h40 + 8'(i), 1'b1);
    txe = 1'b0;
    wait_wr_low(20);
    check("t4_level_pre", level, 5);
    #2 reset_in = 1'b0;
    exp_q.delete();
    #1;
    check("t4_wr", wr, 1);
    check("t4_level", level, 0);
    check("t4_reset_out", reset_out, 0);
    check("t4_in_ready", in_ready, 0);
    check("t4_data_out", data_out, 0);
    repeat (2) @(negedge clk);
    reset_in = 1'b1;
    #1 check("t4_reset_out_pre", reset_out, 0);
    @(negedge clk);
    check("t4_reset_out_rel", reset_out, 1);
    check("t4_in_ready_rel", in_ready, 1);
    p0 = pulses;
    repeat (8) @(negedge clk);
    check("t4_discarded", pulses - p0, 0);
    check("t4_level_end", level, 0);

    // Long setup and pulse, no recovery
    wr_pat = 14'b11100011100011;
    b_in_data  = 8'h5A;
    b_in_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) begin
        b_in_data = 8'hC3;
      end else if (k == 1) begin
        b_in_valid = 1'b0;
      end
      if (k == 0)     d_exp = 8'h00;
      else if (k < 7) d_exp = 8'h5A;
      else            d_exp = 8'hC3;
      check($sformatf("t5_wr_%0d", k),
            b_wr, wr_pat[k]);
      check($sformatf("t5_data_%0d", k),
            b_data_out, d_exp);
    end
    check("t5_level_end", b_level, 0);
    check("t5_rd", b_rd, 1);

`ifdef USB_FIFO_TX_STATS_EN
    check("word_count", word_count,
          32'(wc_exp[15:0]));
`else
    check("word_count", word_count, 0);
    check("b_word_count", b_word_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
